// File: rtl/counter_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl_pkg : state/opcode encodings for the counter sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_PAUSE  = 2'd2,
    OP_RESUME = 2'd3
  } op_e;

  function automatic logic cmd_legal(input state_e st, input op_e op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_START:  ok = (st == ST_IDLE) || (st == ST_DONE);
      OP_STOP:   ok = (st == ST_RUN)  || (st == ST_PAUSE);
      OP_PAUSE:  ok = (st == ST_RUN);
      OP_RESUME: ok = (st == ST_PAUSE);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_seq_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// ctrl_prescaler : divide-by-(div+1) strobe generator, holds phase when !en
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  strobe
);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;

  assign strobe = en && (presc_q == div);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == div) ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl : command-driven up-counter sequencer (one-shot/periodic)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int NBIT       = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [NBIT-1:0]       cfg_load,
  input  logic [NBIT-1:0]       cfg_limit,
  input  logic                  cfg_periodic,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic [NBIT-1:0]       cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  tick,
  output logic                  wrap,
  output logic                  cmd_err
);

  state_e                state_q, state_d;
  logic [NBIT-1:0]       cnt_q, cnt_d;
  logic [NBIT-1:0]       load_q, load_d;
  logic [NBIT-1:0]       limit_q, limit_d;
  logic                  periodic_q, periodic_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  ready_q, ready_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;

  logic w_accept;
  logic w_legal;
  logic w_start;
  logic w_strobe;
  op_e  w_op;

  assign w_op     = op_e'(cmd_op);
  assign w_accept = cmd_valid && ready_q;
  assign w_legal  = cmd_legal(state_q, w_op);
  assign w_start  = w_accept && w_legal && (w_op == OP_START);

  // Any accepted command freezes the prescaler, so it beats a coincident tick.
  ctrl_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (w_start),
    .en     ((state_q == ST_RUN) && !w_accept),
    .div    (prescale_q),
    .strobe (w_strobe)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    prescale_d = prescale_q;
    ready_d    = 1'b1;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    err_d      = 1'b0;

    if (w_accept) begin
      if (!w_legal) begin
        err_d = 1'b1;
      end else begin
        case (w_op)
          OP_START: begin
            state_d    = ST_RUN;
            cnt_d      = cfg_load;
            load_d     = cfg_load;
            limit_d    = cfg_limit;
            periodic_d = cfg_periodic;
            prescale_d = cfg_prescale;
          end
          OP_STOP:   state_d = ST_IDLE;
          OP_PAUSE:  state_d = ST_PAUSE;
          OP_RESUME: state_d = ST_RUN;
          default:   state_d = state_q;
        endcase
      end
    end else if (w_strobe) begin
      if (cnt_q != limit_q) begin
        cnt_d  = cnt_q + NBIT'(1);
        tick_d = 1'b1;
      end else if (periodic_q) begin
        cnt_d  = load_q;
        tick_d = 1'b1;
        wrap_d = 1'b1;
      end else begin
        wrap_d  = 1'b1;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      load_q     <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      prescale_q <= '0;
      ready_q    <= 1'b0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      prescale_q <= prescale_d;
      ready_q    <= ready_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign cnt       = cnt_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = (state_q == ST_DONE);
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign cmd_err   = err_q;

endmodule

`default_nettype wire
